// File: rtl/dac_scheduler.sv
`default_nettype none
// ============================================================================
// dac_scheduler: round-robin arbiter feeding an 11-bit serial DAC (SHIFT/LOAD/LDAC)
// Revision: 1.0
// ============================================================================
module dac_scheduler #(
    parameter int CLK_DIV = 4,
    parameter int RNG     = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       dac_data,
    output logic       dac_clk,
    output logic       dac_load,
    output logic       dac_ldac
);

    localparam logic [7:0] C_LAST = 8'(CLK_DIV - 1);
    localparam logic       C_RNG  = 1'(RNG);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2,
        S_LDAC  = 2'd3
    } state_t;

    state_t      r_state, w_nxt_state;
    logic [7:0]  r_cnt, w_nxt_cnt;
    logic        r_phase, w_nxt_phase;
    logic [3:0]  r_bit, w_nxt_bit;
    logic [10:0] r_shift, w_nxt_shift;
    logic        r_last_ch1;
    logic        w_gnt0, w_gnt1, w_idle, w_cnt_end;

    assign w_idle    = (r_state == S_IDLE) && reset;
    assign w_cnt_end = (r_cnt == C_LAST);
    // Ties go to the channel not served last; a lone requester always wins.
    assign w_gnt0    = w_idle && req0 && (!req1 || r_last_ch1);
    assign w_gnt1    = w_idle && req1 && (!req0 || !r_last_ch1);
    assign gnt0      = w_gnt0;
    assign gnt1      = w_gnt1;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_phase = r_phase;
        w_nxt_bit   = r_bit;
        w_nxt_shift = r_shift;
        case (r_state)
            S_IDLE: begin
                if (w_gnt0 || w_gnt1) begin
                    w_nxt_state = S_SHIFT;
                    w_nxt_cnt   = 8'd0;
                    w_nxt_phase = 1'b0;
                    w_nxt_bit   = 4'd0;
                    w_nxt_shift = w_gnt1 ? {2'b01, C_RNG, data1} : {2'b00, C_RNG, data0};
                end
            end
            S_SHIFT: begin
                if (w_cnt_end) begin
                    w_nxt_cnt   = 8'd0;
                    w_nxt_phase = ~r_phase;
                    if (r_phase) begin
                        w_nxt_shift = {r_shift[9:0], 1'b0};
                        if (r_bit == 4'd10) begin
                            w_nxt_state = S_LOAD;
                            w_nxt_bit   = 4'd0;
                        end else begin
                            w_nxt_bit = r_bit + 4'd1;
                        end
                    end
                end else begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
            S_LOAD: begin
                if (w_cnt_end) begin
                    w_nxt_cnt   = 8'd0;
                    w_nxt_state = S_LDAC;
                end else begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
            S_LDAC: begin
                if (w_cnt_end) begin
                    w_nxt_cnt   = 8'd0;
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_cnt = r_cnt + 8'd1;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they align with the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 8'd0;
            r_phase    <= 1'b0;
            r_bit      <= 4'd0;
            r_shift    <= 11'd0;
            r_last_ch1 <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            dac_data   <= 1'b0;
            dac_clk    <= 1'b0;
            dac_load   <= 1'b1;
            dac_ldac   <= 1'b1;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt    <= w_nxt_cnt;
            r_phase  <= w_nxt_phase;
            r_bit    <= w_nxt_bit;
            r_shift  <= w_nxt_shift;
            if (w_gnt0 || w_gnt1) begin
                r_last_ch1 <= w_gnt1;
            end
            busy     <= (w_nxt_state != S_IDLE);
            done     <= (w_nxt_state == S_LDAC) && (w_nxt_cnt == C_LAST);
            dac_data <= (w_nxt_state == S_SHIFT) && w_nxt_shift[10];
            dac_clk  <= (w_nxt_state == S_SHIFT) && !w_nxt_phase;
            dac_load <= (w_nxt_state != S_LOAD);
            dac_ldac <= (w_nxt_state != S_LDAC);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_scheduler.sv
`default_nettype none
// ============================================================================
// tb_dac_scheduler: directed bench for dac_scheduler (CLK_DIV=4 and CLK_DIV=1)
// Revision: 1.0
// ============================================================================
module tb_dac_scheduler;

    logic       clk = 1'b0;
    logic       rst4, rst1, req0, req1;
    logic [7:0] data0, data1;
    logic       g0_4, g1_4, busy4, done4, dd4, dclk4, dload4, dldac4;
    logic       g0_1, g1_1, busy1, done1, dd1, dclk1, dload1, dldac1;
    int         n_assert = 0;
    int         n_fail   = 0;

    localparam logic [7:0] IDLE_O = 8'b0000_1100;

    always #5 clk = ~clk;

    dac_scheduler #(.CLK_DIV(4), .RNG(0)) dut (
        .clk(clk), .reset(rst4), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(g0_4), .gnt1(g1_4), .busy(busy4), .done(done4), .dac_data(dd4),
        .dac_clk(dclk4), .dac_load(dload4), .dac_ldac(dldac4)
    );

    dac_scheduler #(.CLK_DIV(1), .RNG(0)) dut1 (
        .clk(clk), .reset(rst1), .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(g0_1), .gnt1(g1_1), .busy(busy1), .done(done1), .dac_data(dd1),
        .dac_clk(dclk1), .dac_load(dload1), .dac_ldac(dldac1)
    );

    wire [7:0] o4 = {busy4, done4, dd4, dclk4, dload4, dldac4, g0_4, g1_4};
    wire [7:0] o1 = {busy1, done1, dd1, dclk1, dload1, dldac1, g0_1, g1_1};

    function automatic logic [7:0] obs(input int d);
        return (d == 4) ? o4 : o1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp,
                         input logic [15:0] mask);
        n_assert++;
        assert ((got & mask) === (exp & mask)) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (mask %b)", tag, got, exp, mask);
        end
    endtask

    // Checks one transaction from its grant cycle through the done cycle.
    task automatic txn(input int d, input int ch, input logic [10:0] word, input bit keep,
                       input int pulse_at, input int raise1_at);
        logic [7:0]  e, m, cur;
        logic        prev;
        logic [10:0] ser;
        int          nfall, b, w;
        #1;
        check($sformatf("grant d%0d ch%0d", d, ch), {8'd0, obs(d)},
              {8'd0, 6'b000011, (ch == 0), (ch == 1)}, 16'h00FF);
        prev  = 1'b0;
        ser   = 11'd0;
        nfall = 0;
        for (int i = 1; i <= 24 * d; i++) begin
            tick();
            if (i == 1 && !keep) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (i == pulse_at)     req0 = 1'b1;
            if (i == pulse_at + 1) req0 = 1'b0;
            if (i == raise1_at)    req1 = 1'b1;
            #1;
            m = 8'hFF;
            if (i <= 22 * d) begin
                b = (i - 1) / (2 * d);
                w = (i - 1) % (2 * d);
                e = {1'b1, 1'b0, word[10-b], (w < d), 4'b1100};
            end else if (i <= 23 * d) begin
                e = 8'b1000_0100;
                m = 8'hDF;
            end else begin
                e = {1'b1, (i == 24 * d), 2'b00, 4'b1000};
                m = 8'hDF;
            end
            cur = obs(d);
            check($sformatf("txn d%0d ch%0d cyc%0d", d, ch, i), {8'd0, cur}, {8'd0, e}, {8'd0, m});
            if (prev && !cur[4]) begin
                ser = {ser[9:0], cur[5]};
                nfall++;
            end
            prev = cur[4];
        end
        check($sformatf("serial d%0d ch%0d", d, ch), {nfall[4:0], ser}, {5'd11, word}, 16'hFFFF);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst4 = 1'b0; rst1 = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        repeat (3) tick();
        check("reset idle", {8'd0, o4}, {8'd0, IDLE_O}, 16'h00FF);
        rst4 = 1'b1;
        tick(); #1;
        check("post-reset idle", {8'd0, o4}, {8'd0, IDLE_O}, 16'h00FF);

        // Single ch0 write of 0xA5
        tick();
        req0 = 1'b1; data0 = 8'hA5;
        txn(4, 0, {3'b000, 8'hA5}, 1'b0, -1, -1);
        tick(); #1;
        check("idle after A5", {8'd0, o4}, {8'd0, IDLE_O}, 16'h00FF);

        // Abort at bit 5 (word 0x3C, bit 5 of word is 1, dac_clk high)
        tick();
        req0 = 1'b1; data0 = 8'h3C;
        #1;
        check("grant abort txn", {8'd0, o4}, {8'd0, 8'b0000_1110}, 16'h00FF);
        tick();
        req0 = 1'b0;
        repeat (40) tick();
        #1;
        check("bit5 before reset", {8'd0, o4}, {8'd0, 8'b1011_1100}, 16'h00FF);
        rst4 = 1'b0;
        tick(); #1;
        check("abort idle", {8'd0, o4}, {8'd0, IDLE_O}, 16'h00FF);
        tick(); #1;
        check("abort idle 2", {8'd0, o4}, {8'd0, IDLE_O}, 16'h00FF);

        // Tie after reset: ch0 first, then alternate, 97 cycles apart
        tick();
        rst4 = 1'b1;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
        txn(4, 0, {3'b000, 8'h11}, 1'b1, -1, -1);
        tick();
        txn(4, 1, {3'b010, 8'h22}, 1'b1, -1, -1);
        tick();
        txn(4, 0, {3'b000, 8'h11}, 1'b1, -1, -1);
        tick();
        txn(4, 1, {3'b010, 8'h22}, 1'b1, -1, -1);
        req0 = 1'b0; req1 = 1'b0;
        tick(); #1;
        check("idle after tie", {8'd0, o4}, {8'd0, IDLE_O}, 16'h00FF);

        // ch1 alone back-to-back despite pointer favouring ch0
        tick();
        req1 = 1'b1; data1 = 8'hFF;
        txn(4, 1, {3'b010, 8'hFF}, 1'b1, -1, -1);
        tick();
        txn(4, 1, {3'b010, 8'hFF}, 1'b0, -1, -1);
        tick(); #1;
        check("idle after FF", {8'd0, o4}, {8'd0, IDLE_O}, 16'h00FF);

        // Short req0 pulse while busy must vanish
        tick();
        req1 = 1'b1; data1 = 8'h5A;
        txn(4, 1, {3'b010, 8'h5A}, 1'b0, 30, -1);
        tick(); #1;
        check("no late gnt0", {8'd0, o4}, {8'd0, IDLE_O}, 16'h00FF);
        tick(); #1;
        check("no late gnt0 2", {8'd0, o4}, {8'd0, IDLE_O}, 16'h00FF);

        // Request arriving while busy waits and is served right after done
        tick();
        req0 = 1'b1; data0 = 8'h80; data1 = 8'h0F;
        txn(4, 0, {3'b000, 8'h80}, 1'b0, -1, 50);
        tick();
        txn(4, 1, {3'b010, 8'h0F}, 1'b0, -1, -1);

        // CLK_DIV=1 instance: 25-cycle transaction
        tick();
        rst1 = 1'b1;
        tick(); #1;
        check("d1 idle", {8'd0, o1}, {8'd0, IDLE_O}, 16'h00FF);
        tick();
        req0 = 1'b1; data0 = 8'h80;
        txn(1, 0, {3'b000, 8'h80}, 1'b0, -1, -1);
        tick(); #1;
        check("d1 idle after", {8'd0, o1}, {8'd0, IDLE_O}, 16'h00FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
